uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port baud_tick  input  1  one-clk pulse per bit period, from the baud rate generator's clk_en.
REQ-005 The block SHALL have ports s0_valid / s1_valid  input  1 each  requester 0/1 has a byte.
REQ-006 The block SHALL have ports s0_data / s1_data  input  DATA_BITS each  requester 0/1 payload.
REQ-007 The block SHALL have ports s0_ready / s1_ready  output  1 each  combinational accept strobe.
REQ-008 The block SHALL have port tx  output  1  serial line; idle high; registered.
REQ-009 The block SHALL have port busy  output  1  high whenever state is not IDLE; registered.
REQ-010 The block SHALL have port grant_id  output  1  requester of the frame in flight; registered.
REQ-011 The block SHALL have port done  output  1  one-clk pulse when a frame's stop bit completes.

Function
REQ-012 States SHALL be IDLE, WAIT_START, START, DATA, STOP.
REQ-013 Handshake: transfer on rising edge with sN_valid && sN_ready; a requester SHALL hold valid and data stable until accepted.
REQ-014 sN_ready SHALL be high only in IDLE, and only for the port selected by arbitration; at most one ready high per cycle.
REQ-015 Arbitration SHALL be round-robin: if only one valid, that port wins; if both, the port not granted last wins.
REQ-016 On acceptance: latch data into a DATA_BITS shift register, set grant_id, update last-grant pointer, go to WAIT_START.
REQ-017 A baud_tick in the acceptance cycle SHALL be ignored; WAIT_START waits for the next baud_tick.
REQ-018 On baud_tick in WAIT_START: tx<=0, go to START.
REQ-019 On baud_tick in START: tx<=bit0 (LSB first), bit counter<=0, go to DATA.
REQ-020 On baud_tick in DATA: if counter==DATA_BITS-1, tx<=1 and go to STOP; else send the next bit and increment the counter.
REQ-021 On baud_tick in STOP: go to IDLE, assert done for that one cycle, keep tx=1.
REQ-022 Every transmitted bit SHALL last exactly one baud_tick interval; the frame is 1 start + DATA_BITS + 1 stop.
REQ-023 Outside IDLE, valid inputs SHALL be ignored and both ready low; arbitration resumes the cycle after done.
REQ-024 Back-to-back: a request pending at done SHALL be accepted on the first IDLE cycle.
REQ-025 Bit counter width SHALL be ceil(log2(DATA_BITS)) or 1, whichever is larger; no wrap beyond DATA_BITS-1.

Reset
REQ-026 While rst is high: state=IDLE, tx=1, busy=0, done=0, grant_id=0, counter=0, shift register=0, and the last-grant pointer set so that port 0 wins the first contention.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 asynchronously); the aborted byte is not retransmitted.

Structure
REQ-028 A shared uart_pkg SHALL hold the state encoding and the DATA_BITS default; CLOCK_FREQ/BAUD_RATE stay in the baud rate generator.
REQ-029 The two-input round-robin selector SHALL be sub-module uart_rr_arb2 (valids, pointer in; one-hot grant out); the baud generator is instantiated beside this block, not inside it.

Verification (bench: baud_tick every 4 clks)
REQ-030 Single byte: s0 sends 0xA5 -> tx per tick 0,1,0,1,0,0,1,0,1,1; done once; grant_id=0; busy for 10 bit periods plus the WAIT_START delay.
REQ-031 Contention: s0=0x11 and s1=0x22 valid together after reset -> 0x11 sent first, then 0x22; then both valid again -> s0 wins again (alternation).
REQ-032 Tick in acceptance cycle: s1 valid arriving in the same clk as baud_tick -> start bit begins on the following tick, not the current one.
REQ-033 Reset mid-DATA (after bit 3 of 0xFF) -> tx=1 the same cycle; busy=0; next request transmits a full fresh frame.
REQ-034 Back-to-back s0 bytes 0x00, 0xFF -> second accepted the cycle after done; no gap other than WAIT_START.
REQ-035 Valid withdrawn never occurs; a protocol checker SHALL flag valid dropping before ready and at most one ready high.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: shared UART transmitter state encoding and frame defaults.
// Rev 1.0
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    START      = 3'd2,
    DATA       = 3'd3,
    STOP       = 3'd4
  } uart_state_e;

  function automatic int cnt_width(input int bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// uart_tx_arbiter_if: two-requester valid/ready byte handshake into the UART arbiter.
// Rev 1.0
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic                 s0_valid;
  logic                 s1_valid;
  logic [DATA_BITS-1:0] s0_data;
  logic [DATA_BITS-1:0] s1_data;
  logic                 s0_ready;
  logic                 s1_ready;

  modport master (
    output s0_valid, s1_valid, s0_data, s1_data,
    input  s0_ready, s1_ready
  );

  modport slave (
    input  s0_valid, s1_valid, s0_data, s1_data,
    output s0_ready, s1_ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_rr_arb2.sv
`default_nettype none
// uart_rr_arb2: two-input round-robin selector producing a one-hot grant.
// Rev 1.0
module uart_rr_arb2
  import uart_pkg::*;
(
  input  wire logic [1:0] valid,
  input  wire logic       last,
  output logic      [1:0] grant
);

  always_comb begin
    grant = valid;
    // On contention the port that did not win last time takes the grant.
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// uart_tx_arbiter: round-robin arbitration of two byte requesters onto one UART tx line.
// Rev 1.0
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        baud_tick,
  uart_tx_arbiter_if.slave bus,
  output logic             tx,
  output logic             busy,
  output logic             grant_id,
  output logic             done
);

  localparam int              CNT_W    = cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

  uart_state_e          state;
  uart_state_e          state_n;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_n;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_n;
  logic                 tx_n;
  logic                 busy_n;
  logic                 grant_id_n;
  logic                 done_n;
  logic                 last;
  logic                 last_n;
  logic [1:0]           grant;

  uart_rr_arb2 u_arb (
    .valid ({bus.s1_valid, bus.s0_valid}),
    .last  (last),
    .grant (grant)
  );

  assign bus.s0_ready = (state == IDLE) && grant[0];
  assign bus.s1_ready = (state == IDLE) && grant[1];

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    cnt_n      = cnt;
    tx_n       = tx;
    grant_id_n = grant_id;
    last_n     = last;
    done_n     = 1'b0;

    unique case (state)
      IDLE: begin
        // Acceptance ignores baud_tick; the start bit waits for the next one.
        if (grant != 2'b00) begin
          shreg_n    = grant[1] ? bus.s1_data : bus.s0_data;
          grant_id_n = grant[1];
          last_n     = grant[1];
          state_n    = WAIT_START;
        end
      end
      WAIT_START: begin
        if (baud_tick) begin
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_n    = shreg[0];
          shreg_n = shreg >> 1;
          cnt_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (cnt == CNT_LAST) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            tx_n    = shreg[0];
            shreg_n = shreg >> 1;
            cnt_n   = cnt + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          tx_n    = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // Port 0 wins the first contention after reset, hence last starts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      grant_id <= 1'b0;
      cnt      <= '0;
      shreg    <= '0;
      last     <= 1'b1;
    end else begin
      state    <= state_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
      grant_id <= grant_id_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      last     <= last_n;
    end
  end

endmodule
`default_nettype wire
